// File: rtl/counter_bcd_reader_if.sv
// counter_bcd_reader_if
// Groups the counter-bank reader's data, control and read-port signals.
//   data_raw  : counter bank, slot 0 in the most significant W bits
//   start     : request a conversion pass (level-sampled while idle)
//   busy      : pass in progress
//   done      : one-cycle pulse when a new digit bank is committed
//   bcd_bank  : committed digits, slot 0 in the top DIGITS*4 bits
//   rd_slot   : read-port slot select
//   rd_digit  : read-port digit select, 0 = ones
//   rd_bcd    : registered selected digit
//   rd_lz     : registered leading-zero flag for the selected digit
// The slave modport is the reader itself; master is the side driving it.
interface counter_bcd_reader_if #(
    parameter int SLOTS  = 16,
    parameter int W      = 16,
    parameter int DIGITS = 5
);
    logic [SLOTS*W-1:0]          data_raw;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic [SLOTS*DIGITS*4-1:0]   bcd_bank;
    logic [$clog2(SLOTS)-1:0]    rd_slot;
    logic [2:0]                  rd_digit;
    logic [3:0]                  rd_bcd;
    logic                        rd_lz;

    modport master (
        output data_raw, start, rd_slot, rd_digit,
        input  busy, done, bcd_bank, rd_bcd, rd_lz
    );

    modport slave (
        input  data_raw, start, rd_slot, rd_digit,
        output busy, done, bcd_bank, rd_bcd, rd_lz
    );
endinterface

// File: rtl/counter_bcd_reader.sv
// counter_bcd_reader
// Snapshots the 16-slot counter bank, converts each slot to BCD with a
// sequential double-dabble engine, and commits all slots to the published
// digit bank in a single edge so readers never see a half-updated bank.
// A registered read port returns one digit plus a leading-zero flag.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   bus     : counter_bcd_reader_if slave modport (bank in, control,
//             committed digits, read port)
module counter_bcd_reader #(
    parameter int SLOTS  = 16,
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    counter_bcd_reader_if.slave  bus
);
    localparam int BCDW = DIGITS * 4;
    localparam int SRW  = BCDW + W;
    localparam int IW   = $clog2(SLOTS);
    localparam int CW   = $clog2(W);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SLOTS*W-1:0]     snap_q;
    logic [BCDW-1:0]        work_q [SLOTS];
    logic [SLOTS*BCDW-1:0]  bank_q;
    logic [SRW-1:0]         sr_q;
    logic [SRW-1:0]         adj_d;
    logic [IW-1:0]          idx_q;
    logic [CW-1:0]          bitcnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [3:0]             rd_bcd_q, rd_bcd_d;
    logic                   rd_lz_q, rd_lz_d;
    logic [BCDW-1:0]        rd_slot_bits;
    logic [W-1:0]           snap_slot;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    always_comb begin
        adj_d = sr_q;
        for (int n = 0; n < DIGITS; n++) begin
            if (adj_d[W+4*n +: 4] >= 4'd5) begin
                adj_d[W+4*n +: 4] = adj_d[W+4*n +: 4] + 4'd3;
            end
        end
    end

    // Slot currently being converted, taken from the snapshot so that
    // changes on data_raw during a pass have no effect.
    always_comb begin
        snap_slot = snap_q[SLOTS*W-1 - int'(idx_q)*W -: W];
    end

    // Next-state logic: one LOAD/SHIFT x W/STORE sequence per slot, then a
    // single DONE cycle that commits the whole bank.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (bitcnt_q == CW'(W-1)) state_d = STORE;
            STORE:   state_d = (idx_q == IW'(SLOTS-1)) ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion datapath and commit. The work bank collects results slot by
    // slot; only the DONE cycle copies it into the published bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q   <= '0;
            bank_q   <= '0;
            sr_q     <= '0;
            idx_q    <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                work_q[s] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        snap_q <= bus.data_raw;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    sr_q     <= {{BCDW{1'b0}}, snap_slot};
                    bitcnt_q <= '0;
                end
                SHIFT: begin
                    sr_q     <= adj_d << 1;
                    bitcnt_q <= bitcnt_q + CW'(1);
                end
                STORE: begin
                    work_q[idx_q] <= sr_q[SRW-1:W];
                    if (idx_q != IW'(SLOTS-1)) begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    for (int s = 0; s < SLOTS; s++) begin
                        bank_q[SLOTS*BCDW-1 - s*BCDW -: BCDW] <= work_q[s];
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read-port lookup. Digits above the top decade read as zero and count
    // as leading zeros; the ones digit is never a leading zero.
    always_comb begin
        rd_slot_bits = bank_q[SLOTS*BCDW-1 - int'(bus.rd_slot)*BCDW -: BCDW];
        rd_bcd_d     = 4'd0;
        rd_lz_d      = 1'b1;
        if (int'(bus.rd_digit) < DIGITS) begin
            rd_bcd_d = rd_slot_bits[4*int'(bus.rd_digit) +: 4];
            rd_lz_d  = (bus.rd_digit != 3'd0) &&
                       ((rd_slot_bits >> (4*int'(bus.rd_digit))) == '0);
        end
    end

    // Read-port registers; they sample bank_q before any same-edge commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bcd_q <= 4'd0;
            rd_lz_q  <= 1'b0;
        end else begin
            rd_bcd_q <= rd_bcd_d;
            rd_lz_q  <= rd_lz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_bank = bank_q;
    assign bus.rd_bcd   = rd_bcd_q;
    assign bus.rd_lz    = rd_lz_q;
endmodule

// File: doc/counter_bcd_reader.md
# counter_bcd_reader

Reads the 16-slot × 16-bit counter bank (`data_raw`) written by the button/switch counter logic. Converts every slot to 5-digit BCD with a sequential double-dabble engine and publishes the result as a tear-free digit bank. A 1-cycle registered read port serves the text-generation circuit one digit at a time. The block sits between the counter register and the text generator in the 100 MHz `clk` domain.

## Interface
- `SLOTS`, 16, number of counters in the bank
- `W`, 16, bits per counter
- `DIGITS`, 5, BCD digits per counter; must satisfy 10^DIGITS > 2^W
- `clk`  in  1  system clock, 100 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `data_raw`  in  SLOTS*W  counter bank; slot k = `data_raw[SLOTS*W-1-k*W -: W]`, so slot 0 = [255:240]
- `start`  in  1  request a conversion pass; level-sampled, honoured only in IDLE
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse: new bank committed
- `bcd_bank`  out  SLOTS*DIGITS*4  committed digits; slot 0 in the top 20 bits; within a slot, digit 4 (ten-thousands) is most significant
- `rd_slot`  in  4  read-port slot select
- `rd_digit`  in  3  read-port digit select; 0 = ones, 4 = ten-thousands
- `rd_bcd`  out  4  selected digit, registered
- `rd_lz`  out  1  selected digit is a leading zero, registered

## Operation
- The design has one clock and a single reset. Reset is asynchronous and active-low.
- The FSM has five states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE: when `start`=1, capture the full `data_raw` into the snapshot register, clear slot index i to 0, set `busy`=1, and go to LOAD. The pass uses only the snapshot; later changes to `data_raw` are ignored.
- LOAD: shift register <= {20'b0, snapshot slot i}, bit counter <= 0, then go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1. After the 16th shift, go to STORE.
- STORE: write the 20-bit BCD result into the work bank at slot i. If i==15, go to DONE; otherwise increment i and go to LOAD.
- DONE: `bcd_bank` <= work bank (all 16 slots in one edge), `done`=1, `busy`=0, then return to IDLE.
- `start` in any state other than IDLE is ignored. It is not queued.
- Read port:
  - `rd_bcd` <= digit `rd_digit` of slot `rd_slot` from `bcd_bank`.
  - If `rd_digit` is 5–7, `rd_bcd` <= 0 and `rd_lz` <= 1.
  - `rd_lz` <= 1 iff `rd_digit`≠0 and that digit and every higher digit of the slot are zero. The ones digit is never a leading zero.
- Arithmetic: the BCD register is DIGITS*4 + W = 36 bits. The largest input, 65535, converts to 6,5,5,3,5 with no overflow.
- Reset (asserted at any time, including mid-pass):
  - state = IDLE, `busy`=0, `done`=0.
  - `bcd_bank`, work bank, snapshot, `rd_bcd` and `rd_lz` are all cleared to 0.
  - No partial result is committed.

## Timing
- Let E0 be the edge at which `start` is sampled in IDLE. `busy` is high from E0.
- Slot k:
  - LOAD at E(18k+1).
  - Shifts at E(18k+2)..E(18k+17).
  - STORE at E(18k+18).
- Slot 15 STORE is at E288. At E289 `bcd_bank` updates, `done` rises and `busy` falls; `done` falls at E290.
- A pass takes 289 cycles from start to commit.
- A `start` held high through E289 launches the next pass at E290 (back-to-back).
- `bcd_bank` is constant between commits, so the display never sees a partially updated bank.
- Read-port latency is 1 cycle: address presented before edge N, data valid after edge N.
- Read-port and commit in the same edge: the read returns the pre-commit bank value.

## Test plan
- Set slots 0..15 to 0,1,…,15, pulse `start` → `done` exactly 289 cycles later. Check slot 0 = 00000, slot 15 = 00015, and `busy` low after `done`.
- Set slot 3 = 65535 and slot 4 = 9999 → slot 3 digits 6,5,5,3,5; slot 4 digits 0,9,9,9,9. Reading slot 4 digit 4 gives `rd_bcd`=0, `rd_lz`=1. Reading slot 4 digit 3 gives 9, `rd_lz`=0.
- Start a pass with slot 0 = 42, change slot 0 to 7 at cycle 50 → committed slot 0 = 00042. `bcd_bank` must be unchanged before E289.
- Hold `start` high for 600 cycles → `done` pulses at E289 and again at E579. `start` pulses at cycles 10 and 200 → they are ignored.
- Assert `reset_n`=0 at cycle 150 of a pass → `busy`/`done` go 0 at once and `bcd_bank`=0. After release with no `start`, `done` never asserts.
- Read sweep with slot 7 = 100:
  - `rd_digit` 0..7 → `rd_bcd` 0,0,1,0,0,0,0,0 with 1-cycle latency.
  - `rd_lz` 0,0,0,1,1,1,1,1.
